// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and sizing helpers for the APB4 register front end
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // First byte address past the decoded word registers.
  function automatic int reg_addr_limit(input int num_regs);
    return num_regs * 4;
  endfunction

  // Counter width able to hold 0..timeout.
  function automatic int to_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage : apb_pkg

`default_nettype wire

// File: rtl/apb_addr_check.sv
// ============================================================================
// Module      : apb_addr_check
// Description : Combinational word-alignment and range decoder for APB addresses
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_addr_check
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_addr_err
);

  localparam int REG_ADDR_LIMIT = reg_addr_limit(NUM_REGS);

  logic w_misaligned;
  logic w_out_of_range;

  assign w_misaligned = |i_addr[1:0];

  // A limit beyond the address space means every aligned address decodes.
  generate
    if ((ADDR_WIDTH < 31) && (REG_ADDR_LIMIT >= (1 << ADDR_WIDTH))) begin : g_range_full
      assign w_out_of_range = 1'b0;
    end else begin : g_range_cmp
      assign w_out_of_range = (i_addr >= ADDR_WIDTH'(REG_ADDR_LIMIT));
    end
  endgenerate

  assign o_addr_err = w_misaligned | w_out_of_range;

endmodule : apb_addr_check

`default_nettype wire

// File: rtl/apb_slave_if.sv
// ============================================================================
// Module      : apb_slave_if
// Description : APB4 completer that issues one single-cycle register-file
//               request per transfer, with address checking and a wait timeout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] RegADDR,
  output logic [DATA_WIDTH-1:0] RegWDATA,
  output logic                  RegWRITE,
  output logic                  RegENABLE,
  output logic [STRB_WIDTH-1:0] RegSTRB,
  input  logic [DATA_WIDTH-1:0] RegRDATA,
  input  logic                  RegREADY,
  input  logic                  RegSLVERR
);

  localparam int TO_WIDTH = to_width(TIMEOUT);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TO_WIDTH-1:0]   r_to_cnt;
  logic [TO_WIDTH-1:0]   w_to_cnt_nxt;

  logic                  w_setup;
  logic                  w_addr_err;
  logic                  w_wait_timeout;

  logic [DATA_WIDTH-1:0] r_prdata,    w_prdata_nxt;
  logic                  r_pready,    w_pready_nxt;
  logic                  r_pslverr,   w_pslverr_nxt;
  logic [ADDR_WIDTH-1:0] r_reg_addr,  w_reg_addr_nxt;
  logic [DATA_WIDTH-1:0] r_reg_wdata, w_reg_wdata_nxt;
  logic                  r_reg_write, w_reg_write_nxt;
  logic                  r_reg_enable, w_reg_enable_nxt;
  logic [STRB_WIDTH-1:0] r_reg_strb,  w_reg_strb_nxt;

  apb_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_addr_check (
    .i_addr     (PADDR),
    .o_addr_err (w_addr_err)
  );

  assign w_setup        = PSEL & ~PENABLE;
  assign w_wait_timeout = (r_to_cnt == TO_LAST);

  // State register
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_state_nxt = w_addr_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = PSEL ? WAIT : IDLE;
      end
      WAIT: begin
        if (!PSEL) begin
          w_state_nxt = IDLE;
        end else if (RegREADY || w_wait_timeout) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output and counter next values; response fields default to zero so they
  // are only non-zero alongside PREADY.
  always_comb begin
    w_prdata_nxt     = '0;
    w_pready_nxt     = 1'b0;
    w_pslverr_nxt    = 1'b0;
    w_reg_enable_nxt = 1'b0;
    w_reg_addr_nxt   = r_reg_addr;
    w_reg_wdata_nxt  = r_reg_wdata;
    w_reg_write_nxt  = r_reg_write;
    w_reg_strb_nxt   = r_reg_strb;
    w_to_cnt_nxt     = r_to_cnt;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_reg_addr_nxt  = PADDR;
          w_reg_wdata_nxt = PWDATA;
          w_reg_write_nxt = PWRITE;
          w_reg_strb_nxt  = PWRITE ? PSTRB : '0;
          if (w_addr_err) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
          end else begin
            w_reg_enable_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        w_to_cnt_nxt = '0;
      end
      WAIT: begin
        if (PSEL) begin
          if (RegREADY) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = RegSLVERR;
            w_prdata_nxt  = r_reg_write ? '0 : RegRDATA;
          end else if (w_wait_timeout) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
          end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_prdata     <= '0;
      r_pready     <= 1'b0;
      r_pslverr    <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_wdata  <= '0;
      r_reg_write  <= 1'b0;
      r_reg_enable <= 1'b0;
      r_reg_strb   <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_prdata     <= w_prdata_nxt;
      r_pready     <= w_pready_nxt;
      r_pslverr    <= w_pslverr_nxt;
      r_reg_addr   <= w_reg_addr_nxt;
      r_reg_wdata  <= w_reg_wdata_nxt;
      r_reg_write  <= w_reg_write_nxt;
      r_reg_enable <= w_reg_enable_nxt;
      r_reg_strb   <= w_reg_strb_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
    end
  end

  assign PRDATA    = r_prdata;
  assign PREADY    = r_pready;
  assign PSLVERR   = r_pslverr;
  assign RegADDR   = r_reg_addr;
  assign RegWDATA  = r_reg_wdata;
  assign RegWRITE  = r_reg_write;
  assign RegENABLE = r_reg_enable;
  assign RegSTRB   = r_reg_strb;

endmodule : apb_slave_if

`default_nettype wire

// File: tb/tb_apb_slave_if.sv
// ============================================================================
// Module      : tb_apb_slave_if
// Description : Self-checking bench for apb_slave_if with a behavioural
//               register file answering RegREADY the cycle after RegENABLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_if;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] RegADDR, RegWDATA;
  logic        RegWRITE, RegENABLE;
  logic [3:0]  RegSTRB;
  logic [31:0] RegRDATA  = '0;
  logic        RegREADY  = 1'b0;
  logic        RegSLVERR = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_slave_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STRB_WIDTH (4),
    .NUM_REGS   (16),
    .TIMEOUT    (15)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .RegADDR   (RegADDR),
    .RegWDATA  (RegWDATA),
    .RegWRITE  (RegWRITE),
    .RegENABLE (RegENABLE),
    .RegSTRB   (RegSTRB),
    .RegRDATA  (RegRDATA),
    .RegREADY  (RegREADY),
    .RegSLVERR (RegSLVERR)
  );

  // Register-file model with optional stall and error injection
  logic [31:0] mem [16] = '{default: 32'h0};
  logic        stub_en  = 1'b1;
  logic        stub_err = 1'b0;
  int          en_cnt     = 0;
  int          pready_cnt = 0;
  logic [31:0] en_addr  = '0;
  logic [31:0] en_wdata = '0;
  logic        en_write = 1'b0;
  logic [3:0]  en_strb  = '0;

  always @(posedge PCLK) begin
    RegREADY  <= RegENABLE & stub_en;
    RegSLVERR <= RegENABLE & stub_en & stub_err;
    if (RegENABLE) begin
      en_cnt   <= en_cnt + 1;
      en_addr  <= RegADDR;
      en_wdata <= RegWDATA;
      en_write <= RegWRITE;
      en_strb  <= RegSTRB;
      RegRDATA <= mem[RegADDR[5:2]];
      if (RegWRITE) begin
        for (int b = 0; b < 4; b++) begin
          if (RegSTRB[b]) mem[RegADDR[5:2]][8*b +: 8] <= RegWDATA[8*b +: 8];
        end
      end
    end
    if (PREADY) pready_cnt <= pready_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Full APB transfer; returns with PSEL low one cycle after the response,
  // so an immediate following call is a back-to-back setup phase.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output int lat, output int ens);
    int e0;
    e0 = en_cnt;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat = 1;
    while (!PREADY && lat < 40) begin
      @(posedge PCLK); #1;
      lat++;
    end
    rdata = PRDATA;
    err   = PSLVERR;
    ens   = en_cnt - e0;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat, ens;
    xfer(v.wr, v.addr, v.wdata, v.strb, rd, er, lat, ens);
    check({tag, " prdata"},  rd, v.exp_rdata);
    check({tag, " pslverr"}, {31'b0, er}, {31'b0, v.exp_err});
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " regenable pulses"}, ens, v.exp_en);
    if (v.exp_en == 1) begin
      check({tag, " regaddr"},  en_addr, v.addr);
      check({tag, " regwrite"}, {31'b0, en_write}, {31'b0, v.wr});
      check({tag, " regstrb"},  {28'b0, en_strb}, {28'b0, (v.wr ? v.strb : 4'h0)});
      if (v.wr) check({tag, " regwdata"}, en_wdata, v.wdata);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, ens, p0, e0;

    vecs[0] = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 3, 1};
    vecs[1] = '{1'b0, 32'h08, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 3, 1};
    vecs[2] = '{1'b1, 32'h0C, 32'h12345678, 4'h3, 32'h0,        1'b0, 3, 1};
    vecs[3] = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h00005678, 1'b0, 3, 1};
    vecs[4] = '{1'b1, 32'h40, 32'hBAD0BAD0, 4'hF, 32'h0,        1'b1, 1, 0};
    vecs[5] = '{1'b0, 32'h06, 32'h0,        4'h0, 32'h0,        1'b1, 1, 0};
    vecs[6] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'h0,        1'b0, 3, 1};
    vecs[7] = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0, 3, 1};

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check("reset pready",    {31'b0, PREADY},    32'h0);
    check("reset pslverr",   {31'b0, PSLVERR},   32'h0);
    check("reset prdata",    PRDATA,             32'h0);
    check("reset regenable", {31'b0, RegENABLE}, 32'h0);
    check("reset regaddr",   RegADDR,            32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      @(posedge PCLK); #1;
    end

    // Back-to-back write, read, write with no idle cycles
    p0 = pready_cnt; e0 = en_cnt;
    xfer(1'b1, 32'h00, 32'h11111111, 4'hF, rd, er, lat, ens);
    check("b2b w0 latency", lat, 3);
    xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, lat, ens);
    check("b2b r0 prdata", rd, 32'h11111111);
    check("b2b r0 latency", lat, 3);
    xfer(1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, rd, er, lat, ens);
    check("b2b w3c latency", lat, 3);
    check("b2b regenable pulses", en_cnt - e0, 3);
    check("b2b pready pulses", pready_cnt - p0, 3);
    @(posedge PCLK); #1;
    xfer(1'b0, 32'h3C, 32'h0, 4'h0, rd, er, lat, ens);
    check("b2b readback 3c", rd, 32'hA5A5A5A5);

    // RegREADY stuck low: timeout response
    stub_en = 1'b0;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ens);
    stub_en = 1'b1;
    check("timeout latency", lat, 17);
    check("timeout pslverr", {31'b0, er}, 32'h1);
    check("timeout prdata", rd, 32'h0);
    check("timeout regenable pulses", ens, 1);

    // Register-file error passed through
    stub_err = 1'b1;
    xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, ens);
    stub_err = 1'b0;
    check("regslverr pslverr", {31'b0, er}, 32'h1);
    check("regslverr latency", lat, 3);

    // Reset asserted while in WAIT
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    check("rst-wait pready",   {31'b0, PREADY},    32'h0);
    check("rst-wait pslverr",  {31'b0, PSLVERR},   32'h0);
    check("rst-wait prdata",   PRDATA,             32'h0);
    check("rst-wait regaddr",  RegADDR,            32'h0);
    check("rst-wait regwdata", RegWDATA,           32'h0);
    check("rst-wait regwrite", {31'b0, RegWRITE},  32'h0);
    check("rst-wait regstrb",  {28'b0, RegSTRB},   32'h0);
    check("rst-wait regenable",{31'b0, RegENABLE}, 32'h0);
    p0 = pready_cnt; e0 = en_cnt;
    PRESETn = 1'b1;
    // PSEL with PENABLE but no setup phase must be ignored in IDLE
    repeat (4) @(posedge PCLK);
    #1;
    check("rst-wait no pready", pready_cnt - p0, 0);
    check("idle access ignored", en_cnt - e0, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;

    // PSEL dropped while waiting
    stub_en = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h18;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    p0 = pready_cnt;
    repeat (20) @(posedge PCLK);
    #1;
    stub_en = 1'b1;
    check("psel-drop no pready", pready_cnt - p0, 0);
    xfer(1'b0, 32'h3C, 32'h0, 4'h0, rd, er, lat, ens);
    check("psel-drop recovery prdata", rd, 32'hA5A5A5A5);
    check("psel-drop recovery latency", lat, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule : tb_apb_slave_if

`default_nettype wire

// File: doc/apb_slave_if.md
Name: apb_slave_if

Overview:
APB4 completer front end that sits directly upstream of the register file and drives its RegADDR/RegWDATA/RegWRITE/RegENABLE/RegSTRB interface. It tracks the APB setup/access phases and issues exactly one single-cycle register-file request per transfer. It waits for RegREADY and returns PRDATA/PREADY/PSLVERR. It also rejects misaligned and out-of-range addresses and bounds the wait with a timeout.

Parameters:
ADDR_WIDTH, 32, APB and register address width
DATA_WIDTH, 32, data width
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
NUM_REGS, 16, number of decoded word registers; valid byte addresses are 0 to NUM_REGS*4-4
TIMEOUT, 15, maximum WAIT cycles before an error response; must be at least 1

Ports:
PCLK  in  1  clock; all logic on the rising edge
PRESETn  in  1  synchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  STRB_WIDTH  write byte strobes
PRDATA  out  DATA_WIDTH  read data, valid while PREADY=1
PREADY  out  1  transfer complete
PSLVERR  out  1  error, valid while PREADY=1
RegADDR  out  ADDR_WIDTH  register address
RegWDATA  out  DATA_WIDTH  register write data
RegWRITE  out  1  register write select
RegENABLE  out  1  single-cycle request strobe
RegSTRB  out  STRB_WIDTH  register byte strobes
RegRDATA  in  DATA_WIDTH  register read data
RegREADY  in  1  register access done; asserted the cycle after RegENABLE
RegSLVERR  in  1  register error, sampled with RegREADY

Behaviour:
- Reset (PRESETn=0 at a PCLK edge): state=IDLE; all outputs 0; timeout counter 0. Reset mid-transfer aborts the transfer, and no PREADY is produced for it.
- All outputs are registered.
- FSM states:
  - IDLE: on PSEL=1 and PENABLE=0, capture PADDR, PWDATA, PWRITE and PSTRB into the Reg* outputs. On a read, RegSTRB is forced to 0.
    - If PADDR[1:0]!=0 or PADDR>=NUM_REGS*4, go to RESP with err=1; RegENABLE is never asserted.
    - Otherwise go to ISSUE.
  - ISSUE: RegENABLE=1 for exactly this cycle. Next state is WAIT and the counter is cleared.
  - WAIT: RegENABLE=0.
    - On RegREADY=1: latch PRDATA = RegRDATA on a read and 0 on a write; err = RegSLVERR; go to RESP.
    - Else, if counter == TIMEOUT-1: err=1, PRDATA=0, go to RESP.
    - Else the counter increments.
  - RESP: PREADY=1 and PSLVERR=err for exactly one cycle, then IDLE.
- Nominal latency: setup cycle T0, then ISSUE at T1, WAIT at T2 (RegREADY seen), RESP at T3. This gives 2 wait states; the transfer completes at the end of T3.
- Error latency: setup T0, RESP at T1 with PSLVERR=1 and PRDATA=0. An errored write never reaches the register file.
- Back-to-back: a new setup phase in the cycle after RESP is accepted normally.
- Protocol abort: PSEL=0 in ISSUE, WAIT or RESP returns to IDLE next cycle, clears PREADY, and drives no response. A request already issued in ISSUE is not retracted.
- PSEL=1 with PENABLE=1 while in IDLE (no setup phase) is ignored and the FSM stays in IDLE.
- PREADY=0 in every state except RESP. PSLVERR and PRDATA are 0 whenever PREADY=0.
- The Reg* address, data, write and strobe outputs hold their values until the next accepted setup phase.

Decomposition:
- Shared package apb_pkg holds:
  - enum state_t {IDLE, ISSUE, WAIT, RESP}
  - localparam REG_ADDR_LIMIT = NUM_REGS*4
  - localparam TO_WIDTH = $clog2(TIMEOUT+1)
- One sub-module is natural: apb_addr_check, a combinational alignment/range decoder producing addr_err.
- The FSM and timeout counter stay in apb_slave_if.

Test Plan:
- Write PADDR=0x08, PWDATA=0xDEADBEEF, PSTRB=0xF: RegENABLE high for exactly 1 cycle with RegADDR=0x08 and RegWRITE=1; PREADY at access cycle 3 with PSLVERR=0.
- Read PADDR=0x08 after that write: RegSTRB=0, PRDATA=0xDEADBEEF with PREADY=1 and PSLVERR=0. Then a partial write with PSTRB=0x3 and PWDATA=0x12345678 followed by a read returns 0x00005678.
- Errored transfers: PADDR=0x40, and separately PADDR=0x06, each give PREADY=1 and PSLVERR=1 in the first access cycle with PRDATA=0 and RegENABLE never asserted. A following read of 0x3C is unaffected.
- Stubbed RegREADY held at 0: PREADY=1 and PSLVERR=1 exactly TIMEOUT (15) WAIT cycles after ISSUE, with PRDATA=0.
- Back-to-back write 0x00, read 0x00, write 0x3C with no idle cycles: three single-cycle RegENABLE pulses and three PREADY pulses, with correct data.
- Abort cases:
  - PRESETn=0 asserted in WAIT: all outputs 0 at the next edge and no PREADY.
  - PSEL dropped in WAIT: FSM returns to IDLE and no PREADY.
